// File: rtl/ds_pkg.sv
// Shared types and constants for the multiplexed 4-digit 7-segment scanner.
package ds_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam int N_DIGITS = 4;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // bit0 = a ... bit6 = g
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // One displayed frame: nibbles, decimal points and per-digit blanking.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  mask;
  } disp_t;

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-high a..g segment pattern.
module hex7seg
  import ds_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/ds_scan_ctrl.sv
// Digit scan scheduler: blank gap before every digit, double-buffered
// display data that only swaps on frame boundaries.
module ds_scan_ctrl
  import ds_pkg::*;
#(
  parameter int SHOW_CYC  = 4096,
  parameter int BLANK_CYC = 64,
  parameter int CNT_W     = 13
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic        LOAD,
  input  logic [15:0] VALUE,
  input  logic [3:0]  DP,
  input  logic [3:0]  BLANK_MASK,
  output logic        DS_A,
  output logic        DS_B,
  output logic        DS_C,
  output logic        DS_D,
  output logic        DS_E,
  output logic        DS_F,
  output logic        DS_G,
  output logic        DS_DP,
  output logic        DS_EN1,
  output logic        DS_EN2,
  output logic        DS_EN3,
  output logic        DS_EN4,
  output logic        FRAME,
  output logic        BUSY_PEND
);

  localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;

  if (BLANK_CYC < 1) begin : g_bad_blank
    $error("ds_scan_ctrl: BLANK_CYC must be >= 1");
  end
  if (SHOW_CYC < 1) begin : g_bad_show
    $error("ds_scan_ctrl: SHOW_CYC must be >= 1");
  end
  if ((MAX_CYC - 1) >= (1 << CNT_W)) begin : g_bad_cntw
    $error("ds_scan_ctrl: CNT_W too narrow for SHOW_CYC/BLANK_CYC");
  end

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_t           state, nstate;
  logic [1:0]       digit, ndigit;
  logic [CNT_W-1:0] cnt, ncnt;
  disp_t            act, nact, pend, npend, din;
  logic             pflag, nflag;
  logic             boundary;

  logic [3:0] en_q;
  logic [6:0] seg_q, seg_dec;
  logic       dp_q, frame_q;
  logic [1:0] sel;
  logic [3:0] nib;

  assign din      = '{value: VALUE, dp: DP, mask: BLANK_MASK};
  assign boundary = (state == SHOW) && (digit == 2'(N_DIGITS - 1)) &&
                    (cnt == SHOW_LAST) && ENABLE;

  always_comb begin
    nstate = state;
    ndigit = digit;
    ncnt   = cnt;
    if (!ENABLE) begin
      nstate = IDLE;
      ndigit = '0;
      ncnt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          nstate = BLANK;
          ndigit = '0;
          ncnt   = '0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            nstate = SHOW;
            ncnt   = '0;
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            nstate = BLANK;
            ndigit = digit + 1'b1;
            ncnt   = '0;
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
        default: nstate = IDLE;
      endcase
    end
  end

  // While dark there is nothing to tear, so loads go straight to active.
  always_comb begin
    nact  = act;
    npend = pend;
    nflag = pflag;
    if (state == IDLE) begin
      if (LOAD) begin
        nact  = din;
        nflag = 1'b0;
      end
    end else if (boundary) begin
      if (LOAD) begin
        nact  = din;
        nflag = 1'b0;
      end else if (pflag) begin
        nact  = pend;
        nflag = 1'b0;
      end
    end else if (LOAD) begin
      npend = din;
      nflag = 1'b1;
    end
  end

  // Outputs are registered from next-state values so they line up with state.
  assign sel = 2'd3 - ndigit;
  assign nib = nact.value[{sel, 2'b00} +: 4];

  hex7seg u_hex (
    .nib (nib),
    .seg (seg_dec)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      digit   <= '0;
      cnt     <= '0;
      act     <= '0;
      pend    <= '0;
      pflag   <= 1'b0;
      en_q    <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state   <= nstate;
      digit   <= ndigit;
      cnt     <= ncnt;
      act     <= nact;
      pend    <= npend;
      pflag   <= nflag;
      frame_q <= boundary;
      if (nstate == SHOW) begin
        en_q  <= 4'b1000 >> ndigit;
        seg_q <= nact.mask[sel] ? 7'h00 : seg_dec;
        dp_q  <= nact.mask[sel] ? 1'b0 : nact.dp[sel];
      end else begin
        en_q  <= '0;
        seg_q <= '0;
        dp_q  <= 1'b0;
      end
    end
  end

  assign DS_A      = seg_q[SEG_A];
  assign DS_B      = seg_q[SEG_B];
  assign DS_C      = seg_q[SEG_C];
  assign DS_D      = seg_q[SEG_D];
  assign DS_E      = seg_q[SEG_E];
  assign DS_F      = seg_q[SEG_F];
  assign DS_G      = seg_q[SEG_G];
  assign DS_DP     = dp_q;
  assign DS_EN1    = en_q[3];
  assign DS_EN2    = en_q[2];
  assign DS_EN3    = en_q[1];
  assign DS_EN4    = en_q[0];
  assign FRAME     = frame_q;
  assign BUSY_PEND = pflag;

endmodule

// File: tb/tb_ds_scan_ctrl.sv
// Scanner bench: frame-position reference model plus directed and random stimulus.
module tb_ds_scan_ctrl;

  localparam int SHOW  = 8;
  localparam int BLNK  = 2;
  localparam int SLOT  = SHOW + BLNK;
  localparam int FRM   = 4 * SLOT;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] VALUE = '0;
  logic [3:0]  DP = '0;
  logic [3:0]  BLANK_MASK = '0;
  logic DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G, DS_DP;
  logic DS_EN1, DS_EN2, DS_EN3, DS_EN4, FRAME, BUSY_PEND;

  ds_scan_ctrl #(.SHOW_CYC(SHOW), .BLANK_CYC(BLNK), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .LOAD(LOAD), .VALUE(VALUE),
    .DP(DP), .BLANK_MASK(BLANK_MASK),
    .DS_A(DS_A), .DS_B(DS_B), .DS_C(DS_C), .DS_D(DS_D), .DS_E(DS_E),
    .DS_F(DS_F), .DS_G(DS_G), .DS_DP(DS_DP),
    .DS_EN1(DS_EN1), .DS_EN2(DS_EN2), .DS_EN3(DS_EN3), .DS_EN4(DS_EN4),
    .FRAME(FRAME), .BUSY_PEND(BUSY_PEND)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Model: t = cycles since scanning started; position in frame gives digit/phase.
  bit          run = 0;
  int          t = 0;
  logic [23:0] m_act = '0, m_pend = '0;   // {value, dp, mask}
  bit          m_pf = 0, m_frm = 0;
  logic [14:0] exp_o = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %h exp %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {DS_EN1, DS_EN2, DS_EN3, DS_EN4, DS_G, DS_F, DS_E, DS_D, DS_C, DS_B, DS_A,
            DS_DP, FRAME, BUSY_PEND};
  endfunction

  task automatic model();
    logic [23:0] din;
    bit bnd;
    int pos, d;
    logic [3:0] en;
    logic [6:0] sg;
    logic dpb;
    din = {VALUE, DP, BLANK_MASK};
    if (!RST_N) begin
      run = 0; t = 0; m_act = '0; m_pend = '0; m_pf = 0; m_frm = 0;
    end else begin
      bnd = run && (t % FRM == FRM - 1) && ENABLE;
      m_frm = bnd;
      if (!run) begin
        if (LOAD) begin m_act = din; m_pf = 0; end
      end else if (bnd) begin
        if (LOAD) begin m_act = din; m_pf = 0; end
        else if (m_pf) begin m_act = m_pend; m_pf = 0; end
      end else if (LOAD) begin
        m_pend = din; m_pf = 1;
      end
      if (!ENABLE) run = 0;
      else if (!run) begin run = 1; t = 0; end
      else t++;
    end
    en = '0; sg = '0; dpb = 1'b0;
    pos = t % FRM;
    if (run && (pos % SLOT) >= BLNK) begin
      d   = pos / SLOT;
      en  = 4'b1000 >> d;
      if (!m_act[3-d]) begin
        sg  = HEX[m_act[23-4*d -: 4]];
        dpb = m_act[7-d];
      end
    end
    exp_o = {en, sg, dpb, m_frm, m_pf};
  endtask

  task automatic step();
    @(posedge CLK);
    model();
    #1;
    chk("outs", {17'd0, outs()}, {17'd0, exp_o});
  endtask

  task automatic load_cyc(input logic [15:0] v, input logic [3:0] d, input logic [3:0] m);
    VALUE = v; DP = d; BLANK_MASK = m; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
  endtask

  // Advance until the model sits at frame position p (next edge leaves it).
  task automatic wait_pos(input int p);
    bit hit = 0;
    for (int i = 0; i < 3 * FRM; i++) begin
      if (run && (t % FRM == p)) begin hit = 1; break; end
      step();
    end
    chk("wait_pos", 32'(hit), 32'd1);
  endtask

  initial begin
    int nfrm;
    // 1: reset held with ENABLE high
    RST_N = 1'b0; ENABLE = 1'b1;
    repeat (3) step();
    chk("rst_outs", {17'd0, outs()}, 32'd0);
    RST_N = 1'b1;
    repeat (14) step();

    // 2: load in IDLE, then scan
    ENABLE = 1'b0;
    step();
    load_cyc(16'h12AF, 4'h0, 4'h0);
    ENABLE = 1'b1;
    repeat (20) step();
    nfrm = 0;
    for (int i = 0; i < 2 * FRM; i++) begin
      step();
      nfrm += FRAME;
    end
    chk("frame_cnt", 32'(nfrm), 32'd2);

    // 3: mid-frame load during digit 2
    wait_pos(14);
    load_cyc(16'h0000, 4'h0, 4'h0);
    chk("busy_set", 32'(BUSY_PEND), 32'd1);
    wait_pos(FRM - 1);
    step();
    chk("busy_clr", 32'(BUSY_PEND), 32'd0);
    repeat (SLOT) step();

    // 4: pending 1111 overridden by a load on the boundary edge
    wait_pos(15);
    load_cyc(16'h1111, 4'h0, 4'h0);
    wait_pos(FRM - 1);
    load_cyc(16'h8888, 4'h0, 4'h0);
    wait_pos(5);
    chk("bnd_seg", 32'({DS_G, DS_F, DS_E, DS_D, DS_C, DS_B, DS_A}), 32'h7F);
    repeat (FRM) step();

    // 5: decimal point and blanking mask
    wait_pos(20);
    load_cyc(16'h12AF, 4'b0100, 4'b0001);
    repeat (2 * FRM) step();

    // 6: drop enable during digit 3, then restart from digit 1
    wait_pos(24);
    ENABLE = 1'b0;
    step();
    chk("off_outs", {17'd0, outs()}, 32'd0);
    ENABLE = 1'b1;
    repeat (BLNK + 2) step();
    chk("restart_en1", 32'(DS_EN1), 32'd1);

    // Random soak
    for (int i = 0; i < 3000; i++) begin
      RST_N      = ($urandom_range(0, 499) != 0);
      ENABLE     = ($urandom_range(0, 99) != 0);
      LOAD       = ($urandom_range(0, 7) == 0);
      VALUE      = 16'($urandom);
      DP         = 4'($urandom);
      BLANK_MASK = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
      step();
    end
    LOAD = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ds_scan_ctrl.md
Name: ds_scan_ctrl

Overview:
Time-multiplexing scheduler for the shared 4-digit 7-segment display. The segment bus (DS_A..DS_G, DS_DP) is shared by four digits; the block grants it to one digit at a time via DS_EN1..DS_EN4. It inserts a blanking gap between digits to suppress ghosting and double-buffers the displayed value so updates land only on frame boundaries. Sits directly under top, replacing the fixed enable tie-off and the free-running divider output on DS_C.

Parameters:
SHOW_CYC, 4096, CLK cycles a digit is lit per slot (>=1)
BLANK_CYC, 64, CLK cycles all enables are off before each digit (>=1; elaboration error if 0)
CNT_W, 13, slot counter width; must hold max(SHOW_CYC, BLANK_CYC)-1 (elaboration error otherwise)

Ports:
CLK  in  1  system clock
RST_N  in  1  reset; synchronous, active-low
ENABLE  in  1  1 = scan, 0 = display dark
LOAD  in  1  one-cycle strobe: capture VALUE/DP/BLANK_MASK into pending buffer
VALUE  in  16  four hex digits; [15:12] -> DS_EN1 (leftmost) ... [3:0] -> DS_EN4
DP  in  4  decimal points; bit3 -> digit 1 ... bit0 -> digit 4
BLANK_MASK  in  4  1 = digit forced dark (enable still scanned, segments 0); same bit order
DS_A..DS_G  out  1 each  segment lines, active-high
DS_DP  out  1  decimal point, active-high
DS_EN1..DS_EN4  out  1 each  digit enables, active-high, at most one high
FRAME  out  1  one-cycle pulse when digit 4's slot ends (frame boundary)
BUSY_PEND  out  1  pending buffer holds data not yet shown

Behaviour:
- Reset (RST_N=0 at edge): state IDLE, digit index 0, counter 0, active and pending buffers 0, pending flag 0; all outputs 0.
- All outputs registered; no combinational input-to-output path.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: outputs 0. ENABLE=1 -> BLANK, digit 0, counter 0.
  - BLANK: enables and segments 0; stays BLANK_CYC cycles (counter 0..BLANK_CYC-1), then -> SHOW, counter 0.
  - SHOW: enable of current digit =1; segments = hex decode of active nibble, DS_DP = active DP bit, segments/DP forced 0 if BLANK_MASK bit set. Lasts SHOW_CYC cycles, then -> BLANK with digit index +1 (3 wraps to 0).
  - ENABLE=0 in any state -> IDLE on the next edge; all outputs 0 from that edge. Digit index restarts at 0 on re-enable.
- Slot period = BLANK_CYC+SHOW_CYC; frame = 4 slots.
- FRAME: high for exactly the cycle following the SHOW->BLANK transition out of digit 3 (aligned with BLANK of digit 0).
- Buffering:
  - LOAD=1 -> pending <= inputs, pending flag <= 1 (later LOAD overwrites earlier).
  - At the frame-boundary edge (SHOW digit 3 -> BLANK digit 0), if pending flag: active <= pending, flag <= 0.
  - LOAD on the boundary edge: active <= inputs directly, flag <= 0 (newest wins).
  - In IDLE, LOAD copies straight into active (no tearing possible while dark).
  - Active buffer never changes mid-frame while scanning.
- BUSY_PEND = pending flag.
- Hex encoding (a..g): 0->3F,1->06,2->5B,3->4F,4->66,5->6D,6->7D,7->07,8->7F,9->6F,A->77,b->7C,C->39,d->5E,E->79,F->71 (bit0=a ... bit6=g).
- Counter compares are exact equality on terminal count; no overflow path.

Decomposition:
- Package ds_pkg: state enum (IDLE, BLANK, SHOW), N_DIGITS=4, segment bit-index constants, hex-to-segment constant table.
- One sub-module: hex7seg (4-bit nibble in, 7-bit segment pattern out, combinational), instanced once on the muxed nibble.

Test Plan (SHOW_CYC=8, BLANK_CYC=2, CNT_W=4):
1. RST_N=0 for 3 cycles with ENABLE=1 -> all outputs 0; release -> 2 cycles dark, then DS_EN1=1 for exactly 8 cycles.
2. ENABLE=1, VALUE=16'h12AF loaded in IDLE -> sequence EN1 segs 06, EN2 segs 5B, EN3 segs 77, EN4 segs 71; each separated by 2 dark cycles; FRAME pulses once every 40 cycles.
3. Mid-frame (during EN2) LOAD VALUE=16'h0000 -> BUSY_PEND=1; EN3/EN4 still show A,F; after FRAME, EN1 shows 3F and BUSY_PEND=0.
4. LOAD asserted on the exact boundary edge with VALUE=16'h8888 while pending holds 16'h1111 -> next frame shows 7F on all digits.
5. DP=4'b0100, BLANK_MASK=4'b0001 -> DS_DP=1 only during EN2; during EN4 enable high, segments and DP 0.
6. ENABLE dropped during SHOW of digit 2 -> all outputs 0 next edge; re-enable -> BLANK then digit 0 (EN1), not digit 3.
